pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Port: CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: RST_N  input  1  reset; asynchronous and active-low.
REQ-004 Port: IMEM_REQ  output  1  instruction-memory read request; one cycle per fetch.
REQ-005 Port: IMEM_ADDR  output  32  fetch address; valid while IMEM_REQ=1.
REQ-006 Port: IMEM_RVALID  input  1  read data valid; one pulse per request, no earlier than one cycle after IMEM_REQ.
REQ-007 Port: IMEM_RDATA  input  32  instruction word; sampled when IMEM_RVALID=1.
REQ-008 Port: INST_VALID  output  1  instruction presented to decode.
REQ-009 Port: INST  output  32  held instruction word.
REQ-010 Port: INST_PC  output  32  address of INST; this is the PC fed to the branch processor.
REQ-011 Port: INST_READY  input  1  decode/execute consumes INST this cycle.
REQ-012 Port: REDIRECT  input  1  taken branch/jump for the instruction currently held.
REQ-013 Port: NewPC  input  32  redirect target from the branch processor.
REQ-014 Port: MISALIGN  output  1  sticky fault: redirect target not word aligned.

Function
REQ-015 States: IDLE, REQ, WAIT, HOLD, DROP, HALT; internal 32-bit PC register.
REQ-016 IDLE -> REQ unconditionally on the first rising edge.
REQ-017 REQ: IMEM_REQ=1, IMEM_ADDR=PC; next state WAIT, or DROP if REDIRECT=1.
REQ-018 WAIT: on IMEM_RVALID, capture INST<=IMEM_RDATA and INST_PC<=PC, then enter HOLD; otherwise remain in WAIT.
REQ-019 HOLD: INST_VALID=1; INST and INST_PC are stable until the handshake completes.
REQ-020 HOLD with INST_READY=1 and REDIRECT=0: PC<=PC+32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0), then enter REQ.
REQ-021 HOLD with REDIRECT=1, whether or not INST_READY is set: redirect wins, the held instruction is retired, PC<=NewPC, then enter REQ.
REQ-022 REDIRECT in WAIT: PC<=NewPC, then enter DROP.
REQ-023 REDIRECT in REQ: PC<=NewPC, then enter DROP.
REQ-024 DROP: the next IMEM_RVALID response is discarded (INST unchanged, INST_VALID=0), then enter REQ; REDIRECT in DROP reloads PC and stays in DROP.
REQ-025 REDIRECT in IDLE or HALT is ignored.
REQ-026 At most one outstanding memory request at any time.
REQ-027 IMEM_RVALID outside WAIT/DROP is ignored.
REQ-028 Redirect with NewPC[1:0]!=2'b00: PC not loaded, MISALIGN<=1, enter HALT.
REQ-029 HALT: IMEM_REQ=0 and INST_VALID=0 until reset.
REQ-030 INST_VALID=1 only in HOLD; IMEM_REQ=1 only in REQ.
REQ-031 Minimum fetch cadence is 3 cycles per instruction (REQ, WAIT, HOLD) with 1-cycle memory latency and INST_READY held high.

Reset
REQ-032 RST_N=0 forces immediately, without a clock: state=IDLE, PC=RESET_PC, IMEM_REQ=0, IMEM_ADDR=RESET_PC, INST_VALID=0, INST=32'h0000_0013, INST_PC=RESET_PC, MISALIGN=0.
REQ-033 Reset asserted mid-fetch abandons the outstanding request.
REQ-034 An IMEM_RVALID arriving in the first cycles after reset release is ignored (state IDLE or REQ).

Verification
REQ-035 Reset release, memory returns 32'h00A00093 one cycle after each request, INST_READY=1 -> IMEM_ADDR sequence 0x0, 0x4, 0x8; INST_VALID pulses every 3rd cycle with INST_PC=0x0, 0x4, 0x8.
REQ-036 HOLD at INST_PC=0x10 with INST_READY=0 for 5 cycles -> INST and INST_PC stable, IMEM_REQ=0 throughout; INST_READY=1 -> next IMEM_ADDR=0x14.
REQ-037 HOLD at 0x20, REDIRECT=1 with NewPC=0x100 and INST_READY=1 in the same cycle -> next IMEM_ADDR=0x100, no fetch of 0x24.
REQ-038 REDIRECT with NewPC=0x40 during WAIT for 0x8 -> the 0x8 response is dropped (INST_VALID stays 0), next IMEM_ADDR=0x40, and the next INST_PC=0x40.
REQ-039 REDIRECT with NewPC=0x102 -> MISALIGN=1, no further IMEM_REQ; RST_N low then high -> MISALIGN=0, fetch restarts at RESET_PC.
REQ-040 PC=32'hFFFF_FFFC consumed without redirect -> next IMEM_ADDR=32'h0000_0000; RST_N pulsed low during WAIT -> outputs at reset values asynchronously, and a late IMEM_RVALID is ignored.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch sequencer: issues one memory read at a time, holds the returned word for
// decode, and follows branch redirects while discarding responses that belong to a stale PC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        INST_VALID,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    input  logic        INST_READY,
    input  logic        REDIRECT,
    input  logic [31:0] NewPC,
    output logic        MISALIGN
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        misalign_q, misalign_d;

    logic redirect_ok;
    logic redirect_bad;

    assign redirect_ok  = REDIRECT && (NewPC[1:0] == 2'b00);
    assign redirect_bad = REDIRECT && (NewPC[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        misalign_d = misalign_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;

            S_REQ: begin
                if (redirect_bad) begin
                    misalign_d = 1'b1;
                    state_d    = S_HALT;
                end else if (redirect_ok) begin
                    pc_d    = NewPC;
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_bad) begin
                    misalign_d = 1'b1;
                    state_d    = S_HALT;
                end else if (redirect_ok) begin
                    pc_d    = NewPC;
                    // A response landing in the redirect cycle is already the stale one.
                    state_d = IMEM_RVALID ? S_REQ : S_DROP;
                end else if (IMEM_RVALID) begin
                    inst_d    = IMEM_RDATA;
                    inst_pc_d = pc_q;
                    state_d   = S_HOLD;
                end
            end

            S_HOLD: begin
                if (redirect_bad) begin
                    misalign_d = 1'b1;
                    state_d    = S_HALT;
                end else if (redirect_ok) begin
                    pc_d    = NewPC;
                    state_d = S_REQ;
                end else if (INST_READY) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end

            S_DROP: begin
                if (redirect_bad) begin
                    misalign_d = 1'b1;
                    state_d    = S_HALT;
                end else begin
                    if (redirect_ok) begin
                        pc_d = NewPC;
                    end
                    if (IMEM_RVALID) begin
                        state_d = S_REQ;
                    end
                end
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            inst_pc_q  <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign IMEM_REQ   = (state_q == S_REQ);
    assign IMEM_ADDR  = pc_q;
    assign INST_VALID = (state_q == S_HOLD);
    assign INST       = inst_q;
    assign INST_PC    = inst_pc_q;
    assign MISALIGN   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a cycle table for the basic fetch/redirect flow, then
// hand-written sequences for stalls, redirects, misaligned halts, PC wrap and async reset.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        RST_N;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        INST_VALID;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        INST_READY;
    logic        REDIRECT;
    logic [31:0] NewPC;
    logic        MISALIGN;

    pc_fetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IMEM_REQ   (IMEM_REQ),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_RVALID(IMEM_RVALID),
        .IMEM_RDATA (IMEM_RDATA),
        .INST_VALID (INST_VALID),
        .INST       (INST),
        .INST_PC    (INST_PC),
        .INST_READY (INST_READY),
        .REDIRECT   (REDIRECT),
        .NewPC      (NewPC),
        .MISALIGN   (MISALIGN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ready;
        logic        redirect;
        logic [31:0] new_pc;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h00A0_0093;
    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;
    logic auto_mem = 1'b0;
    logic saw_24   = 1'b0;

    function automatic vec_t mk(input logic rdy, input logic rdr, input logic [31:0] npc,
                                input logic rv, input logic [31:0] rd, input logic ereq,
                                input logic [31:0] eaddr, input logic ev,
                                input logic [31:0] einst, input logic [31:0] epc);
        vec_t v;
        v.ready = rdy; v.redirect = rdr; v.new_pc = npc; v.rvalid = rv; v.rdata = rd;
        v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev; v.e_inst = einst; v.e_pc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock; in auto mode memory answers one cycle after each request.
    task automatic step();
        logic rp;
        rp = IMEM_REQ;
        if (IMEM_REQ && IMEM_ADDR == 32'h24) saw_24 = 1'b1;
        @(posedge CLK);
        #1;
        if (auto_mem) begin
            IMEM_RVALID = rp;
            IMEM_RDATA  = rp ? ADDI : 32'h0;
        end
    endtask

    task automatic wait_hold(input logic [31:0] pc);
        int n;
        n = 0;
        while (!(INST_VALID && INST_PC == pc) && n < 60) begin
            step();
            n++;
        end
        chk($sformatf("reach_hold_%h", pc), {31'd0, INST_VALID && INST_PC == pc}, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},      {31'd0, IMEM_REQ},   32'd0);
        chk({tag, "_addr"},     IMEM_ADDR,           32'h0);
        chk({tag, "_valid"},    {31'd0, INST_VALID}, 32'd0);
        chk({tag, "_inst"},     INST,                NOP);
        chk({tag, "_inst_pc"},  INST_PC,             32'h0);
        chk({tag, "_misalign"}, {31'd0, MISALIGN},   32'd0);
    endtask

    initial begin
        int bad_cnt;
        RST_N = 1'b1; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
        INST_READY = 1'b0; REDIRECT = 1'b0; NewPC = 32'h0;
        #1 RST_N = 1'b0;
        #2 chk_reset("por");

        //       rdy rdr newpc   rv rdata  req addr  v  inst  inst_pc
        vq.push_back(mk(0, 0, 32'h0,   1, BAD,  0, 32'h0,   0, NOP,  32'h0));  // IDLE
        vq.push_back(mk(1, 0, 32'h0,   1, BAD,  1, 32'h0,   0, NOP,  32'h0));  // REQ
        vq.push_back(mk(1, 0, 32'h0,   1, ADDI, 0, 32'h0,   0, NOP,  32'h0));  // WAIT
        vq.push_back(mk(1, 0, 32'h0,   0, 0,    0, 32'h0,   1, ADDI, 32'h0));  // HOLD
        vq.push_back(mk(1, 0, 32'h0,   0, 0,    1, 32'h4,   0, ADDI, 32'h0));
        vq.push_back(mk(1, 0, 32'h0,   1, ADDI, 0, 32'h4,   0, ADDI, 32'h0));
        vq.push_back(mk(1, 0, 32'h0,   0, 0,    0, 32'h4,   1, ADDI, 32'h4));
        vq.push_back(mk(1, 0, 32'h0,   0, 0,    1, 32'h8,   0, ADDI, 32'h4));
        vq.push_back(mk(1, 0, 32'h0,   1, ADDI, 0, 32'h8,   0, ADDI, 32'h4));
        vq.push_back(mk(0, 0, 32'h0,   0, 0,    0, 32'h8,   1, ADDI, 32'h8));  // stall
        vq.push_back(mk(0, 0, 32'h0,   1, BAD,  0, 32'h8,   1, ADDI, 32'h8));  // stray rvalid
        vq.push_back(mk(1, 0, 32'h0,   0, 0,    0, 32'h8,   1, ADDI, 32'h8));
        vq.push_back(mk(1, 0, 32'h0,   0, 0,    1, 32'hC,   0, ADDI, 32'h8));
        vq.push_back(mk(1, 1, 32'h40,  0, 0,    0, 32'hC,   0, ADDI, 32'h8));  // redirect in WAIT
        vq.push_back(mk(1, 0, 32'h0,   1, BAD,  0, 32'h40,  0, ADDI, 32'h8));  // DROP
        vq.push_back(mk(1, 0, 32'h0,   0, 0,    1, 32'h40,  0, ADDI, 32'h8));
        vq.push_back(mk(1, 0, 32'h0,   1, EBRK, 0, 32'h40,  0, ADDI, 32'h8));
        vq.push_back(mk(1, 1, 32'h100, 0, 0,    0, 32'h40,  1, EBRK, 32'h40)); // redirect in HOLD
        vq.push_back(mk(1, 1, 32'h200, 0, 0,    1, 32'h100, 0, EBRK, 32'h40)); // redirect in REQ
        vq.push_back(mk(1, 0, 32'h0,   1, BAD,  0, 32'h200, 0, EBRK, 32'h40)); // DROP
        vq.push_back(mk(1, 0, 32'h0,   0, 0,    1, 32'h200, 0, EBRK, 32'h40));

        @(negedge CLK) RST_N = 1'b1;
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            INST_READY  = vq[i].ready;
            REDIRECT    = vq[i].redirect;
            NewPC       = vq[i].new_pc;
            IMEM_RVALID = vq[i].rvalid;
            IMEM_RDATA  = vq[i].rdata;
            chk($sformatf("vec%0d_req", i),   {31'd0, IMEM_REQ},   {31'd0, vq[i].e_req});
            chk($sformatf("vec%0d_addr", i),  IMEM_ADDR,           vq[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'd0, INST_VALID}, {31'd0, vq[i].e_valid});
            chk($sformatf("vec%0d_inst", i),  INST,                vq[i].e_inst);
            chk($sformatf("vec%0d_pc", i),    INST_PC,             vq[i].e_pc);
            step();
        end

        // Stall at 0x10, then redirect-with-ready at 0x20.
        REDIRECT = 1'b0; IMEM_RVALID = 1'b0; INST_READY = 1'b1;
        RST_N = 1'b0;
        #1 chk_reset("rst2");
        @(negedge CLK) RST_N = 1'b1;
        #1 auto_mem = 1'b1;
        wait_hold(32'h10);
        INST_READY = 1'b0;
        bad_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!INST_VALID || INST != ADDI || INST_PC != 32'h10 || IMEM_REQ) bad_cnt++;
        end
        chk("stall_stable", bad_cnt, 0);
        INST_READY = 1'b1;
        step();
        chk("after_stall_req",  {31'd0, IMEM_REQ}, 32'd1);
        chk("after_stall_addr", IMEM_ADDR, 32'h14);

        wait_hold(32'h20);
        saw_24 = 1'b0;
        REDIRECT = 1'b1; NewPC = 32'h100;
        step();
        REDIRECT = 1'b0;
        chk("redir_req",  {31'd0, IMEM_REQ}, 32'd1);
        chk("redir_addr", IMEM_ADDR, 32'h100);
        wait_hold(32'h100);
        chk("no_fetch_24", {31'd0, saw_24}, 32'd0);

        // Misaligned target halts the unit until reset.
        REDIRECT = 1'b1; NewPC = 32'h102;
        step();
        REDIRECT = 1'b0;
        chk("misalign_set", {31'd0, MISALIGN}, 32'd1);
        chk("misalign_pc_kept", IMEM_ADDR, 32'h104 - 32'h4);
        bad_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (IMEM_REQ || INST_VALID) bad_cnt++;
            step();
        end
        chk("halt_quiet", bad_cnt, 0);
        chk("halt_sticky", {31'd0, MISALIGN}, 32'd1);
        RST_N = 1'b0;
        #1 chk("misalign_clr", {31'd0, MISALIGN}, 32'd0);
        @(negedge CLK) RST_N = 1'b1;
        #1 step();
        chk("restart_req",  {31'd0, IMEM_REQ}, 32'd1);
        chk("restart_addr", IMEM_ADDR, 32'h0);

        // PC wrap, then async reset while a response is outstanding.
        wait_hold(32'h0);
        REDIRECT = 1'b1; NewPC = 32'hFFFF_FFFC;
        step();
        REDIRECT = 1'b0;
        wait_hold(32'hFFFF_FFFC);
        step();
        chk("wrap_req",  {31'd0, IMEM_REQ}, 32'd1);
        chk("wrap_addr", IMEM_ADDR, 32'h0);
        step();
        chk("wrap_wait_addr", IMEM_ADDR, 32'h0);
        RST_N = 1'b0;
        #1 chk_reset("rst_wait");
        auto_mem = 1'b0;
        IMEM_RVALID = 1'b1; IMEM_RDATA = BAD;
        @(negedge CLK) RST_N = 1'b1;
        #1 step();
        chk("late_rvalid_req_inst",  INST, NOP);
        chk("late_rvalid_req_valid", {31'd0, INST_VALID}, 32'd0);
        step();
        IMEM_RVALID = 1'b0;
        chk("late_rvalid_wait_inst",  INST, NOP);
        chk("late_rvalid_wait_valid", {31'd0, INST_VALID}, 32'd0);
        chk("late_rvalid_wait_req",   {31'd0, IMEM_REQ}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
